// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the asynchronous FIFO.
// Brings the write pointer into r_clk through a two-flop synchroniser and
// derives empty and rd_level from it. Issues reads to the registered-output
// memory and hides that one-cycle latency behind a two-entry skid buffer.
// Returns the Gray-coded read pointer to the write domain.
module fifo_read_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic              r_clk,
   input  logic              r_rst_n,
   input  logic [ADDR_W:0]   w_ptr_gray,
   output logic [ADDR_W:0]   r_ptr_gray,
   output logic [ADDR_W-1:0] mem_r_add,
   output logic              mem_r_en,
   output logic              mem_empty,
   input  logic [DATA_W-1:0] mem_r_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              empty,
   output logic [ADDR_W:0]   rd_level
);

   localparam int PW = ADDR_W + 1;

   logic [PW-1:0]     wq1_gray;
   logic [PW-1:0]     wq2_gray;
   logic [PW-1:0]     wq2_bin;
   logic [PW-1:0]     rbin;
   logic [PW-1:0]     rbin_next;
   logic [PW-1:0]     rgray_next;
   logic              inflight;
   logic [1:0]        occ;
   logic [DATA_W-1:0] buf_tail;
   logic              pop;
   logic [2:0]        commit;

   // Two-flop synchroniser; w_ptr_gray is sampled nowhere else in r_clk
   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         wq1_gray <= '0;
         wq2_gray <= '0;
      end else begin
         wq1_gray <= w_ptr_gray;
         wq2_gray <= wq1_gray;
      end
   end

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      wq2_bin = '0;
      for (int i = 0; i < PW; i++) begin
         wq2_bin[i] = ^(wq2_gray >> i);
      end
   end

   // Issue a read only while the words already owed to the buffer leave room
   always_comb begin
      pop        = m_valid & m_ready;
      commit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      mem_r_en   = ~empty & (commit < 3'd2);
      rbin_next  = rbin + {{ADDR_W{1'b0}}, mem_r_en};
      rgray_next = rbin_next ^ (rbin_next >> 1);
   end

   assign mem_r_add = rbin[ADDR_W-1:0];
   assign mem_empty = empty;
   assign m_valid   = (occ != 2'd0);
   assign rd_level  = wq2_bin - rbin;

   // Read pointer, its Gray copy, the empty flag and the read-latency tracker
   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         rbin       <= '0;
         r_ptr_gray <= '0;
         empty      <= 1'b1;
         inflight   <= 1'b0;
      end else begin
         rbin       <= rbin_next;
         r_ptr_gray <= rgray_next;
         empty      <= (rgray_next == wq2_gray);
         inflight   <= mem_r_en;
      end
   end

   // Two-entry in-order skid buffer; m_data is the head, buf_tail the second slot
   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         occ      <= 2'd0;
         m_data   <= '0;
         buf_tail <= '0;
      end else begin
         case ({inflight, pop})
            2'b11: begin
               if (occ == 2'd2) begin
                  m_data   <= buf_tail;
                  buf_tail <= mem_r_data;
               end else begin
                  m_data <= mem_r_data;
               end
            end
            2'b10: begin
               if (occ == 2'd0) begin
                  m_data <= mem_r_data;
               end else begin
                  buf_tail <= mem_r_data;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               m_data <= buf_tail;
               occ    <= occ - 2'd1;
            end
            default: begin
               occ <= occ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: a behavioural registered-read memory,
// a write-side pointer model, and a scoreboard that checks issued addresses
// and delivered words in order.
module tb_fifo_read_ctrl;

   logic        r_clk;
   logic        r_rst_n;
   logic [4:0]  w_ptr_gray;
   logic [4:0]  r_ptr_gray;
   logic [3:0]  mem_r_add;
   logic        mem_r_en;
   logic        mem_empty;
   logic [15:0] mem_r_data;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        empty;
   logic [4:0]  rd_level;

   logic [15:0] mem [16];
   logic [4:0]  wbin;
   logic [15:0] exp_data [$];
   logic [3:0]  exp_addr [$];
   int          checks;
   int          failures;
   int          pop_count;

   fifo_read_ctrl #(.ADDR_W(4), .DATA_W(16)) dut (
      .r_clk      (r_clk),
      .r_rst_n    (r_rst_n),
      .w_ptr_gray (w_ptr_gray),
      .r_ptr_gray (r_ptr_gray),
      .mem_r_add  (mem_r_add),
      .mem_r_en   (mem_r_en),
      .mem_empty  (mem_empty),
      .mem_r_data (mem_r_data),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .empty      (empty),
      .rd_level   (rd_level)
   );

   // Free-running read clock
   initial begin
      r_clk = 1'b0;
      forever #5 r_clk = ~r_clk;
   end

   // Memory read port with one cycle of registered latency
   always @(posedge r_clk) begin
      if (mem_r_en) mem_r_data <= mem[mem_r_add];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic failNote(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: got an event, expected none at %0t", name, $time);
   endtask

   // Write-side model: fill memory, record expectations, advance the Gray pointer
   task automatic applyStimulus(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         mem[wbin[3:0]] = base + 16'(i);
         exp_data.push_back(base + 16'(i));
         exp_addr.push_back(wbin[3:0]);
         wbin = wbin + 5'd1;
      end
      w_ptr_gray = wbin ^ (wbin >> 1);
   endtask

   task automatic applyReset();
      r_rst_n = 1'b0;
      exp_data.delete();
      exp_addr.delete();
      wbin = '0;
      w_ptr_gray = '0;
      repeat (3) @(posedge r_clk);
      #1 r_rst_n = 1'b1;
   endtask

   task automatic nextNeg();
      @(posedge r_clk);
      @(negedge r_clk);
   endtask

   task automatic waitIssue(input string name);
      int k;
      for (k = 0; k < 12; k++) begin
         @(negedge r_clk);
         if (mem_r_en) break;
      end
      if (k == 12) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: got no mem_r_en, expected one within 12 cycles", name);
      end
   endtask

   task automatic waitDrain(input string name);
      int k;
      for (k = 0; k < 60; k++) begin
         @(negedge r_clk);
         if (exp_data.size() == 0 && !m_valid) break;
      end
      if (k == 60) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: got %0d words outstanding, expected 0", name, exp_data.size());
      end
   endtask

   // Scoreboard monitor: compares issue addresses and accepted words in order
   always @(negedge r_clk) begin
      if (r_rst_n) begin
         if (mem_r_en) begin
            if (exp_addr.size() == 0) failNote("spurious_issue");
            else checkOutput("issue_addr", 32'(mem_r_add), 32'(exp_addr.pop_front()));
         end
         if (m_valid && m_ready) begin
            pop_count++;
            if (exp_data.size() == 0) failNote("extra_word");
            else checkOutput("stream_data", 32'(m_data), 32'(exp_data.pop_front()));
         end
         checkOutput("no_issue_when_empty", 32'(mem_r_en & empty), 32'd0);
      end
   end

   initial begin
      int base_pops;
      checks     = 0;
      failures   = 0;
      pop_count  = 0;
      r_rst_n    = 1'b0;
      m_ready    = 1'b0;
      wbin       = '0;
      w_ptr_gray = '0;
      mem_r_data = '0;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      // Test 1: reset holds with a toggling write pointer
      for (int i = 0; i < 4; i++) begin
         @(posedge r_clk);
         #1 w_ptr_gray = 5'(i * 7 + 3);
      end
      @(negedge r_clk);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_mem_r_en", 32'(mem_r_en), 32'd0);
      checkOutput("rst_r_ptr_gray", 32'(r_ptr_gray), 32'd0);
      checkOutput("rst_mem_r_add", 32'(mem_r_add), 32'd0);
      checkOutput("rst_rd_level", 32'(rd_level), 32'd0);
      w_ptr_gray = '0;
      @(posedge r_clk);
      #1 r_rst_n = 1'b1;

      // Test 2: single word, exact latency
      @(posedge r_clk);
      #1 m_ready = 1'b1;
      applyStimulus(1, 16'hA5A5);
      nextNeg();
      nextNeg();
      checkOutput("single_empty_e2", 32'(empty), 32'd1);
      checkOutput("single_level_e2", 32'(rd_level), 32'd1);
      nextNeg();
      checkOutput("single_empty_e3", 32'(empty), 32'd0);
      checkOutput("single_issue_e3", 32'(mem_r_en), 32'd1);
      checkOutput("single_addr_e3", 32'(mem_r_add), 32'd0);
      nextNeg();
      checkOutput("single_empty_e4", 32'(empty), 32'd1);
      checkOutput("single_rptr_e4", 32'(r_ptr_gray), 32'd1);
      checkOutput("single_valid_e4", 32'(m_valid), 32'd0);
      checkOutput("single_issue_e4", 32'(mem_r_en), 32'd0);
      nextNeg();
      checkOutput("single_valid_e5", 32'(m_valid), 32'd1);
      checkOutput("single_data_e5", 32'(m_data), 32'hA5A5);
      nextNeg();
      checkOutput("single_valid_e6", 32'(m_valid), 32'd0);

      // Test 3: full 16-word burst at one word per cycle
      applyReset();
      @(posedge r_clk);
      #1 applyStimulus(16, 16'h1000);
      waitIssue("burst_start");
      for (int i = 0; i < 19; i++) begin
         checkOutput("burst_issue", 32'(mem_r_en), 32'(i < 16));
         if (i < 16) checkOutput("burst_level", 32'(rd_level), 32'(16 - i));
         checkOutput("burst_valid", 32'(m_valid), 32'(i >= 2 && i <= 17));
         if (i == 16) begin
            checkOutput("burst_empty", 32'(empty), 32'd1);
            checkOutput("burst_rptr", 32'(r_ptr_gray), 32'b11000);
            checkOutput("burst_level_end", 32'(rd_level), 32'd0);
         end
         nextNeg();
      end

      // Test 4: backpressure with five words available
      @(posedge r_clk);
      #1 m_ready = 1'b0;
      applyStimulus(5, 16'h2000);
      waitIssue("bp_start");
      for (int i = 0; i < 8; i++) begin
         checkOutput("bp_issue", 32'(mem_r_en), 32'(i < 2));
         if (i >= 2) begin
            checkOutput("bp_valid", 32'(m_valid), 32'd1);
            checkOutput("bp_hold_data", 32'(m_data), 32'h2000);
         end
         nextNeg();
      end
      base_pops = pop_count;
      @(posedge r_clk);
      #1 m_ready = 1'b1;
      waitDrain("bp_drain");
      checkOutput("bp_word_count", 32'(pop_count - base_pops), 32'd5);
      checkOutput("bp_empty", 32'(empty), 32'd1);

      // Test 5: address wrap 14,15,0,1
      applyReset();
      @(posedge r_clk);
      #1 applyStimulus(14, 16'h3000);
      waitDrain("wrap_prefill");
      @(posedge r_clk);
      #1 applyStimulus(4, 16'h4000);
      waitIssue("wrap_start");
      waitDrain("wrap_drain");
      nextNeg();
      checkOutput("wrap_rptr", 32'(r_ptr_gray), 32'b11011);
      checkOutput("wrap_addr", 32'(mem_r_add), 32'd2);
      checkOutput("wrap_level", 32'(rd_level), 32'd0);
      checkOutput("wrap_empty", 32'(empty), 32'd1);

      // Test 6: asynchronous reset in the middle of a burst
      applyReset();
      @(posedge r_clk);
      #1 applyStimulus(10, 16'h5000);
      waitIssue("midrst_start");
      nextNeg();
      nextNeg();
      checkOutput("midrst_busy_issue", 32'(mem_r_en), 32'd1);
      checkOutput("midrst_busy_valid", 32'(m_valid), 32'd1);
      #2 r_rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(m_valid), 32'd0);
      checkOutput("midrst_issue", 32'(mem_r_en), 32'd0);
      checkOutput("midrst_empty", 32'(empty), 32'd1);
      exp_data.delete();
      exp_addr.delete();
      wbin = '0;
      w_ptr_gray = '0;
      repeat (2) @(posedge r_clk);
      #1 r_rst_n = 1'b1;
      repeat (3) nextNeg();
      checkOutput("post_rst_empty", 32'(empty), 32'd1);
      checkOutput("post_rst_rptr", 32'(r_ptr_gray), 32'd0);
      checkOutput("post_rst_addr", 32'(mem_r_add), 32'd0);
      checkOutput("post_rst_level", 32'(rd_level), 32'd0);
      checkOutput("post_rst_valid", 32'(m_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
